// File: rtl/video_rect_filler_if.sv
// rtl/video_rect_filler_if.sv - command and video-memory write bundle for video_rect_filler
interface video_rect_filler_if #(
   parameter int X_BITS     = 8,
   parameter int Y_BITS     = 8,
   parameter int COLOR_BITS = 3
) ();
   logic                     iCmdValid;
   logic                     oCmdReady;
   logic [X_BITS-1:0]        iX0;
   logic [Y_BITS-1:0]        iY0;
   logic [X_BITS:0]          iWidth;
   logic [Y_BITS:0]          iHeight;
   logic [COLOR_BITS-1:0]    iColor;
   logic                     iMemGrant;
   logic                     oWriteEnable;
   logic [X_BITS+Y_BITS-1:0] oWriteAddress;
   logic [COLOR_BITS-1:0]    oWriteData;
   logic                     oBusy;
   logic                     oDone;

   // Command source and memory arbiter side
   modport master (
      output iCmdValid, iX0, iY0, iWidth, iHeight, iColor, iMemGrant,
      input  oCmdReady, oWriteEnable, oWriteAddress, oWriteData, oBusy, oDone
   );

   // Filler side
   modport slave (
      input  iCmdValid, iX0, iY0, iWidth, iHeight, iColor, iMemGrant,
      output oCmdReady, oWriteEnable, oWriteAddress, oWriteData, oBusy, oDone
   );
endinterface

// File: rtl/video_rect_filler.sv
// rtl/video_rect_filler.sv - fills a clipped rectangle of video memory with one colour, row-major
module video_rect_filler #(
   parameter int X_BITS     = 8,
   parameter int Y_BITS     = 8,
   parameter int COLOR_BITS = 3
) (
   input  logic                Clock,
   input  logic                Reset,
   video_rect_filler_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Screen extent expressed in the one-bit-wider size arithmetic
   localparam logic [X_BITS:0] X_SPAN = {1'b1, {X_BITS{1'b0}}};
   localparam logic [Y_BITS:0] Y_SPAN = {1'b1, {Y_BITS{1'b0}}};
   localparam logic [X_BITS:0] X_ONE  = (X_BITS+1)'(1);
   localparam logic [Y_BITS:0] Y_ONE  = (Y_BITS+1)'(1);

   state_t                  state_q, state_d;
   logic [X_BITS-1:0]       x0_q, x0_d;
   logic [Y_BITS-1:0]       y0_q, y0_d;
   logic [COLOR_BITS-1:0]   color_q, color_d;
   logic [X_BITS-1:0]       col_last_q, col_last_d;
   logic [Y_BITS-1:0]       row_last_q, row_last_d;
   logic [X_BITS-1:0]       col_q, col_d;
   logic [Y_BITS-1:0]       row_q, row_d;

   logic [X_BITS:0]         room_x, clip_w, clip_w_m1;
   logic [Y_BITS:0]         room_y, clip_h, clip_h_m1;
   logic [X_BITS-1:0]       cur_col;
   logic [Y_BITS-1:0]       cur_row;
   logic                    last_col, last_row;

   // Clip the requested size to the space left before the right/bottom screen edge
   always_comb begin
      room_x    = X_SPAN - {1'b0, bus.iX0};
      room_y    = Y_SPAN - {1'b0, bus.iY0};
      clip_w    = (bus.iWidth  < room_x) ? bus.iWidth  : room_x;
      clip_h    = (bus.iHeight < room_y) ? bus.iHeight : room_y;
      clip_w_m1 = clip_w - X_ONE;
      clip_h_m1 = clip_h - Y_ONE;
      cur_col   = x0_q + col_q;
      cur_row   = y0_q + row_q;
      last_col  = (col_q == col_last_q);
      last_row  = (row_q == row_last_q);
   end

   // Next-state and output decode; counters move only on granted FILL cycles
   always_comb begin
      state_d           = state_q;
      x0_d              = x0_q;
      y0_d              = y0_q;
      color_d           = color_q;
      col_last_d        = col_last_q;
      row_last_d        = row_last_q;
      col_d             = col_q;
      row_d             = row_q;
      bus.oCmdReady     = 1'b0;
      bus.oWriteEnable  = 1'b0;
      bus.oWriteAddress = '0;
      bus.oWriteData    = '0;
      bus.oBusy         = 1'b0;
      bus.oDone         = 1'b0;

      case (state_q)
         S_IDLE: begin
            bus.oCmdReady = 1'b1;
            if (bus.iCmdValid) begin
               x0_d       = bus.iX0;
               y0_d       = bus.iY0;
               color_d    = bus.iColor;
               col_last_d = clip_w_m1[X_BITS-1:0];
               row_last_d = clip_h_m1[Y_BITS-1:0];
               col_d      = '0;
               row_d      = '0;
               if ((clip_w == '0) || (clip_h == '0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FILL;
               end
            end
         end
         S_FILL: begin
            bus.oBusy         = 1'b1;
            bus.oWriteEnable  = bus.iMemGrant;
            bus.oWriteAddress = {cur_row, cur_col};
            bus.oWriteData    = color_q;
            if (bus.iMemGrant) begin
               if (last_col) begin
                  col_d = '0;
                  row_d = row_q + Y_BITS'(1);
                  if (last_row) begin
                     state_d = S_DONE;
                  end
               end else begin
                  col_d = col_q + X_BITS'(1);
               end
            end
         end
         S_DONE: begin
            bus.oBusy = 1'b1;
            bus.oDone = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and command registers; reset aborts any fill in progress
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q    <= S_IDLE;
         x0_q       <= '0;
         y0_q       <= '0;
         color_q    <= '0;
         col_last_q <= '0;
         row_last_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         x0_q       <= x0_d;
         y0_q       <= y0_d;
         color_q    <= color_d;
         col_last_q <= col_last_d;
         row_last_q <= row_last_d;
         col_q      <= col_d;
         row_q      <= row_d;
      end
   end

endmodule
